// File: rtl/axi_lrsc_init_pkg.sv
// Shared types and AXI response codes for the LR/SC initiator.
package axi_lrsc_init_pkg;

  typedef enum logic [1:0] {
    OP_LR    = 2'b00,
    OP_SC    = 2'b01,
    OP_LOAD  = 2'b10,
    OP_STORE = 2'b11
  } lrsc_op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AR   = 3'd1,
    R    = 3'd2,
    WR   = 3'd3,
    B    = 3'd4,
    RSP  = 3'd5
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_bus.sv
// Plain AXI4(+ATOP) bus bundle with master/slave views.
interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned AXI_USER_WIDTH = 1
);
  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;

  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_lock;
  logic [3:0]                aw_cache;
  logic [2:0]                aw_prot;
  logic [3:0]                aw_qos;
  logic [3:0]                aw_region;
  logic [5:0]                aw_atop;
  logic [AXI_USER_WIDTH-1:0] aw_user;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]         w_strb;
  logic                      w_last;
  logic [AXI_USER_WIDTH-1:0] w_user;
  logic                      w_valid;
  logic                      w_ready;

  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [1:0]                b_resp;
  logic [AXI_USER_WIDTH-1:0] b_user;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_lock;
  logic [3:0]                ar_cache;
  logic [2:0]                ar_prot;
  logic [3:0]                ar_qos;
  logic [3:0]                ar_region;
  logic [AXI_USER_WIDTH-1:0] ar_user;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_user, aw_valid, input aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid, input w_ready,
    input  b_id, b_resp, b_user, b_valid, output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid, input ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid, output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_user, aw_valid, output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid, output w_ready,
    output b_id, b_resp, b_user, b_valid, input b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid, output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid, input r_ready
  );
endinterface

// File: rtl/axi_lrsc_initiator.sv
// Single-outstanding AXI initiator for LR/SC (exclusive) and plain load/store.
// Misaligned requests are answered locally with an error and never reach the bus.
module axi_lrsc_initiator
  import axi_lrsc_init_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 0,
  parameter int unsigned AXI_DATA_WIDTH = 0,
  parameter int unsigned AXI_ID_WIDTH   = 0,
  parameter int unsigned AXI_USER_WIDTH = 0,
  parameter logic [AXI_ID_WIDTH-1:0] AXI_ID = '0
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [1:0]                  req_op_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [2:0]                  req_size_i,
  input  logic [AXI_DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] req_strb_i,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                        rsp_excl_o,
  output logic                        rsp_err_o,
  AXI_BUS.Master                      mst
);
  localparam int unsigned STRB_W   = AXI_DATA_WIDTH / 8;
  localparam logic [2:0]  MAX_SIZE = 3'($clog2(STRB_W));

  state_e                    state;
  lrsc_op_e                  op_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [2:0]                size_q;
  logic                      lock_q;
  logic [AXI_DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]         strb_q;
  logic                      ar_valid_q, aw_valid_q, w_valid_q;
  logic                      aw_done, w_done;

  logic [63:0] addr_ext, size_mask;
  logic        misaligned, aw_fire, w_fire, aw_done_n, w_done_n;

  assign addr_ext   = 64'(req_addr_i);
  assign size_mask  = (64'd1 << req_size_i) - 64'd1;
  assign misaligned = (req_size_i > MAX_SIZE) || (|(addr_ext & size_mask));

  assign aw_fire   = aw_valid_q && mst.aw_ready;
  assign w_fire    = w_valid_q && mst.w_ready;
  assign aw_done_n = aw_done || aw_fire;
  assign w_done_n  = w_done || w_fire;

  assign req_ready_o = (state == IDLE);
  assign mst.r_ready = (state == R);
  assign mst.b_ready = (state == B);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      op_q        <= OP_LR;
      addr_q      <= '0;
      size_q      <= '0;
      lock_q      <= 1'b0;
      wdata_q     <= '0;
      strb_q      <= '0;
      ar_valid_q  <= 1'b0;
      aw_valid_q  <= 1'b0;
      w_valid_q   <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_excl_o  <= 1'b0;
      rsp_err_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid_i) begin
          op_q    <= lrsc_op_e'(req_op_i);
          addr_q  <= req_addr_i;
          size_q  <= req_size_i;
          lock_q  <= ~req_op_i[1];
          wdata_q <= req_wdata_i;
          strb_q  <= req_strb_i;
          if (misaligned) begin
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= '0;
            rsp_excl_o  <= 1'b0;
            rsp_err_o   <= 1'b1;
            state       <= RSP;
          end else if (!req_op_i[0]) begin
            ar_valid_q <= 1'b1;
            state      <= AR;
          end else begin
            aw_valid_q <= 1'b1;
            w_valid_q  <= 1'b1;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            state      <= WR;
          end
        end
        AR: if (mst.ar_ready) begin
          ar_valid_q <= 1'b0;
          state      <= R;
        end
        R: if (mst.r_valid) begin
          rsp_valid_o <= 1'b1;
          rsp_rdata_o <= mst.r_data;
          rsp_excl_o  <= (mst.r_resp == RESP_EXOKAY);
          rsp_err_o   <= mst.r_resp[1];
          state       <= RSP;
        end
        WR: begin
          // AW and W complete independently; leave only once both have fired.
          if (aw_fire) begin
            aw_valid_q <= 1'b0;
            aw_done    <= 1'b1;
          end
          if (w_fire) begin
            w_valid_q <= 1'b0;
            w_done    <= 1'b1;
          end
          if (aw_done_n && w_done_n) state <= B;
        end
        B: if (mst.b_valid) begin
          rsp_valid_o <= 1'b1;
          rsp_rdata_o <= '0;
          rsp_err_o   <= mst.b_resp[1];
          if (op_q == OP_SC) begin
            // SC result word: 0 on exclusive success, 1 otherwise.
            rsp_rdata_o[0] <= (mst.b_resp != RESP_EXOKAY);
            rsp_excl_o     <= (mst.b_resp == RESP_EXOKAY);
          end else begin
            rsp_excl_o <= 1'b0;
          end
          state <= RSP;
        end
        RSP: if (rsp_ready_i) begin
          rsp_valid_o <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mst.aw_id     = AXI_ID;
  assign mst.aw_addr   = addr_q;
  assign mst.aw_len    = '0;
  assign mst.aw_size   = size_q;
  assign mst.aw_burst  = 2'b01;
  assign mst.aw_lock   = lock_q;
  assign mst.aw_cache  = '0;
  assign mst.aw_prot   = '0;
  assign mst.aw_qos    = '0;
  assign mst.aw_region = '0;
  assign mst.aw_atop   = '0;
  assign mst.aw_user   = '0;
  assign mst.aw_valid  = aw_valid_q;

  assign mst.w_data  = wdata_q;
  assign mst.w_strb  = strb_q;
  assign mst.w_last  = 1'b1;
  assign mst.w_user  = '0;
  assign mst.w_valid = w_valid_q;

  assign mst.ar_id     = AXI_ID;
  assign mst.ar_addr   = addr_q;
  assign mst.ar_len    = '0;
  assign mst.ar_size   = size_q;
  assign mst.ar_burst  = 2'b01;
  assign mst.ar_lock   = lock_q;
  assign mst.ar_cache  = '0;
  assign mst.ar_prot   = '0;
  assign mst.ar_qos    = '0;
  assign mst.ar_region = '0;
  assign mst.ar_user   = '0;
  assign mst.ar_valid  = ar_valid_q;

  logic unused_rsp_fields;
  assign unused_rsp_fields = ^{mst.b_id, mst.b_user, mst.r_id, mst.r_last, mst.r_user};

endmodule

// File: tb/tb_axi_lrsc_initiator.sv
// Directed bench for axi_lrsc_initiator; the bench plays the AXI slave.
module tb_axi_lrsc_initiator;
  import axi_lrsc_init_pkg::*;

  localparam int AW = 32, DW = 64, IW = 4, UW = 1;
  localparam logic [IW-1:0] ID = 4'h5;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          req_valid = 1'b0, req_ready;
  logic [1:0]    req_op = '0;
  logic [AW-1:0] req_addr = '0;
  logic [2:0]    req_size = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [7:0]    req_strb = '0;
  logic          rsp_valid, rsp_ready = 1'b0, rsp_excl, rsp_err;
  logic [DW-1:0] rsp_rdata;

  int n_chk = 0, n_err = 0;
  int ar_cnt = 0, w_cnt = 0, b_cnt = 0, rsp_cnt = 0;

  AXI_BUS #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW),
            .AXI_USER_WIDTH(UW)) bus ();

  axi_lrsc_initiator #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW),
                       .AXI_USER_WIDTH(UW), .AXI_ID(ID)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_addr_i(req_addr), .req_size_i(req_size), .req_wdata_i(req_wdata),
    .req_strb_i(req_strb),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_excl_o(rsp_excl), .rsp_err_o(rsp_err),
    .mst(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.ar_valid && bus.ar_ready) ar_cnt <= ar_cnt + 1;
    if (bus.w_valid && bus.w_ready)   w_cnt  <= w_cnt + 1;
    if (bus.b_valid && bus.b_ready)   b_cnt  <= b_cnt + 1;
    if (rsp_valid && rsp_ready)       rsp_cnt <= rsp_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a request at a negedge; returns half a cycle after acceptance.
  task automatic send(input logic [1:0] op, input logic [31:0] addr, input logic [2:0] size,
                      input logic [63:0] wdata);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_size = size;
    req_wdata = wdata; req_strb = 8'hFF;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic finish_rsp(input logic [63:0] e_data, input logic e_excl, input logic e_err,
                            input int hold);
    for (int i = 0; i < hold; i++) begin
      chk("rsp_hold_valid", rsp_valid, 1);
      chk("rsp_hold_data", rsp_rdata, e_data);
      chk("rsp_hold_err", rsp_err, e_err);
      chk("req_ready_busy", req_ready, 0);
      @(negedge clk);
    end
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_rdata", rsp_rdata, e_data);
    chk("rsp_excl", rsp_excl, e_excl);
    chk("rsp_err", rsp_err, e_err);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", rsp_valid, 0);
    chk("req_ready_back", req_ready, 1);
  endtask

  task automatic do_read(input logic [1:0] op, input logic [31:0] addr, input logic [2:0] size,
                         input logic [63:0] rdata, input logic [1:0] rresp, input logic e_lock,
                         input logic e_excl, input logic e_err);
    int ar0;
    ar0 = ar_cnt;
    send(op, addr, size, 64'h0);
    chk("ar_valid", bus.ar_valid, 1);
    chk("ar_lock", bus.ar_lock, e_lock);
    chk("ar_len", bus.ar_len, 0);
    chk("ar_addr", bus.ar_addr, addr);
    chk("ar_size", bus.ar_size, size);
    chk("ar_id", bus.ar_id, ID);
    chk("ar_burst", bus.ar_burst, 2'b01);
    chk("r_ready_in_ar", bus.r_ready, 0);
    bus.ar_ready = 1'b1;
    @(negedge clk);
    bus.ar_ready = 1'b0;
    chk("ar_valid_drop", bus.ar_valid, 0);
    chk("r_ready", bus.r_ready, 1);
    bus.r_valid = 1'b1; bus.r_data = rdata; bus.r_resp = rresp;
    @(negedge clk);
    bus.r_valid = 1'b0;
    chk("ar_count", 64'(ar_cnt - ar0), 1);
    finish_rsp(rdata, e_excl, e_err, 0);
  endtask

  task automatic do_write(input logic [1:0] op, input logic [31:0] addr, input logic [63:0] wdata,
                          input logic [1:0] bresp, input int wdelay, input int hold,
                          input logic e_lock, input logic [63:0] e_data, input logic e_excl,
                          input logic e_err);
    int b0, w0, r0;
    b0 = b_cnt; w0 = w_cnt; r0 = rsp_cnt;
    send(op, addr, 3'd3, wdata);
    chk("aw_valid", bus.aw_valid, 1);
    chk("w_valid", bus.w_valid, 1);
    chk("aw_lock", bus.aw_lock, e_lock);
    chk("aw_addr", bus.aw_addr, addr);
    chk("w_last", bus.w_last, 1);
    chk("w_data", bus.w_data, wdata);
    chk("b_ready_in_wr", bus.b_ready, 0);
    // B is offered already in the final request-side handshake cycle.
    bus.aw_ready = 1'b1; bus.w_ready = (wdelay == 0);
    bus.b_valid = 1'b1; bus.b_resp = bresp;
    @(negedge clk);
    bus.aw_ready = 1'b0; bus.w_ready = 1'b0;
    if (wdelay > 0) begin
      for (int i = 0; i < wdelay; i++) begin
        chk("aw_valid_done", bus.aw_valid, 0);
        chk("w_valid_wait", bus.w_valid, 1);
        chk("b_ready_wait", bus.b_ready, 0);
        @(negedge clk);
      end
      bus.w_ready = 1'b1;
      @(negedge clk);
      bus.w_ready = 1'b0;
    end
    chk("w_valid_drop", bus.w_valid, 0);
    for (int i = 0; i < 10 && !bus.b_ready; i++) @(negedge clk);
    chk("b_ready", bus.b_ready, 1);
    chk("b_cnt_pre", 64'(b_cnt - b0), 0);
    @(negedge clk);
    bus.b_valid = 1'b0;
    chk("w_count", 64'(w_cnt - w0), 1);
    finish_rsp(e_data, e_excl, e_err, hold);
    chk("b_count", 64'(b_cnt - b0), 1);
    chk("rsp_count", 64'(rsp_cnt - r0), 1);
  endtask

  task automatic do_misaligned(input logic [1:0] op, input logic [31:0] addr,
                               input logic [2:0] size);
    int ar0;
    ar0 = ar_cnt;
    send(op, addr, size, 64'h0);
    chk("mis_ar_valid", bus.ar_valid, 0);
    chk("mis_aw_valid", bus.aw_valid, 0);
    finish_rsp(64'h0, 1'b0, 1'b1, 0);
    chk("mis_ar_count", 64'(ar_cnt - ar0), 0);
  endtask

  initial begin
    bus.aw_ready = 1'b0; bus.w_ready = 1'b0; bus.ar_ready = 1'b0;
    bus.b_valid = 1'b0; bus.b_resp = '0; bus.b_id = '0; bus.b_user = '0;
    bus.r_valid = 1'b0; bus.r_data = '0; bus.r_resp = '0; bus.r_id = '0;
    bus.r_last = 1'b1; bus.r_user = '0;

    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_ar_valid", bus.ar_valid, 0);
    chk("rst_aw_valid", bus.aw_valid, 0);
    chk("rst_w_valid", bus.w_valid, 0);
    chk("rst_r_ready", bus.r_ready, 0);
    chk("rst_b_ready", bus.b_ready, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_flags", {rsp_excl, rsp_err}, 0);
    chk("rst_aw_lock", bus.aw_lock, 0);
    chk("rst_ar_addr", bus.ar_addr, 0);
    chk("rst_w_data", bus.w_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_read(OP_LR,   32'h1000, 3'd3, 64'hDEAD, RESP_EXOKAY, 1, 1, 0);
    do_read(OP_LOAD, 32'h1004, 3'd2, 64'h1234_5678, RESP_OKAY, 0, 0, 0);
    do_read(OP_LOAD, 32'h2000, 3'd3, 64'hBEEF, RESP_SLVERR, 0, 0, 1);

    do_write(OP_SC,    32'h1000, 64'h5, RESP_EXOKAY, 0, 0, 1, 64'h0, 1, 0);
    do_write(OP_SC,    32'h1000, 64'h5, RESP_OKAY,   0, 0, 1, 64'h1, 0, 0);
    do_write(OP_SC,    32'h1008, 64'h7, RESP_SLVERR, 0, 0, 1, 64'h1, 0, 1);
    do_write(OP_SC,    32'h1000, 64'h9, RESP_EXOKAY, 5, 0, 1, 64'h0, 1, 0);
    do_write(OP_STORE, 32'h3000, 64'hA5A5, RESP_DECERR, 0, 4, 0, 64'h0, 0, 1);
    do_write(OP_STORE, 32'h3008, 64'h1, RESP_OKAY, 2, 0, 0, 64'h0, 0, 0);

    do_misaligned(OP_LR,    32'h1004, 3'd3);
    do_misaligned(OP_LOAD,  32'h1000, 3'd4);
    do_misaligned(OP_STORE, 32'h1001, 3'd1);

    // Abandon a read in R with an asynchronous reset.
    send(OP_LR, 32'h4000, 3'd3, 64'h0);
    bus.ar_ready = 1'b1;
    @(negedge clk);
    bus.ar_ready = 1'b0;
    chk("pre_rst_r_ready", bus.r_ready, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req_ready", req_ready, 1);
    chk("mid_rst_r_ready", bus.r_ready, 0);
    chk("mid_rst_valids", {rsp_valid, bus.ar_valid, bus.aw_valid, bus.w_valid}, 0);
    chk("mid_rst_ar_lock", bus.ar_lock, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_read(OP_LR, 32'h4000, 3'd3, 64'hCAFE, RESP_EXOKAY, 1, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/axi_lrsc_initiator.md
AXI_LRSC_INITIATOR -- requirements
Module: axi_lrsc_initiator

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- AXI_ADDR_WIDTH, 0, address width.
- AXI_DATA_WIDTH, 0, data width; strobe width is AXI_DATA_WIDTH/8.
- AXI_ID_WIDTH, 0, ID width.
- AXI_USER_WIDTH, 0, user width.
- AXI_ID, 0, ID driven on every AW and AR.
REQ-002 Ports (name, direction, width, meaning):
- clk_i, input, 1, clock. One clock only.
- rst_ni, input, 1, reset. Asynchronous, active-low.
- req_valid_i, input, 1, command valid.
- req_ready_o, output, 1, command ready.
- req_op_i, input, 2, operation: 00 LR, 01 SC, 10 LOAD, 11 STORE.
- req_addr_i, input, AXI_ADDR_WIDTH, byte address.
- req_size_i, input, 3, AXI size.
- req_wdata_i, input, AXI_DATA_WIDTH, store data.
- req_strb_i, input, AXI_DATA_WIDTH/8, store strobe.
- rsp_valid_o, output, 1, response valid.
- rsp_ready_i, input, 1, response ready.
- rsp_rdata_o, output, AXI_DATA_WIDTH, read data, or SC result (0 = success, 1 = fail).
- rsp_excl_o, output, 1, exclusive granted (EXOKAY).
- rsp_err_o, output, 1, SLVERR, DECERR or misaligned.
- mst, AXI_BUS.Master, -, AXI master port.

Function
REQ-003 At most one transaction is outstanding. req_ready_o = 1 only in state IDLE.
REQ-004 FSM states are IDLE, AR, R, WR, B, RSP.
- IDLE -> AR on LR or LOAD.
- IDLE -> WR on SC or STORE.
- IDLE -> RSP on misaligned request.
- AR -> R on AR handshake.
- R -> RSP on R handshake.
- WR -> B when both AW and W have handshaked.
- B -> RSP on B handshake.
- RSP -> IDLE on rsp_valid_o && rsp_ready_i.
REQ-005 Request fields are registered on acceptance. Channel valids assert in the cycle after acceptance and hold until their handshake. Payloads are stable while valid.
REQ-006 Every AW/AR is driven with the following fields:
- len = 0, burst = INCR, id = AXI_ID.
- size = registered req_size_i, address = registered address.
- lock = 1 for LR/SC and 0 for LOAD/STORE.
- atop, prot, region, qos, cache and user are 0.
REQ-007 W is single-beat: last = 1, user = 0, data and strb registered.
REQ-008 In WR, AW and W assert together and are independent. Each deasserts after its own handshake; a per-channel done flag tracks completion.
REQ-009 r_ready = 1 only in R. b_ready = 1 only in B. Neither is ever asserted elsewhere.
REQ-010 Misaligned request: the address is not a multiple of 2^size, or size > log2(AXI_DATA_WIDTH/8). No AXI traffic is issued. The response is rsp_err_o = 1, rsp_excl_o = 0, rsp_rdata_o = 0.
REQ-011 LR/LOAD response:
- rsp_rdata_o = r_data.
- rsp_excl_o = 1 iff r_resp = EXOKAY.
- rsp_err_o = 1 iff r_resp[1] = 1.
REQ-012 SC response:
- b_resp = EXOKAY gives rsp_rdata_o = 0 and rsp_excl_o = 1.
- b_resp = OKAY gives rsp_rdata_o = 1 and rsp_excl_o = 0.
- SLVERR or DECERR gives rsp_rdata_o = 1 and rsp_err_o = 1.
REQ-013 STORE response: rsp_rdata_o = 0 and rsp_err_o = b_resp[1].
REQ-014 Response outputs are registered: rsp_valid_o asserts one cycle after the R/B handshake and holds with stable data until rsp_ready_i.
REQ-015 Best-case latency, request acceptance to rsp_valid_o:
- LR: 3 cycles with ar_ready and r_valid immediate.
- SC: 3 cycles with aw_ready, w_ready and b_valid immediate.
REQ-016 A response arriving in the same cycle as the final request-side handshake is not accepted until the FSM reaches R/B.

Reset
REQ-017 While rst_ni = 0:
- The FSM is IDLE.
- All valid and ready outputs are 0, except req_ready_o = 1.
- rsp_rdata_o, rsp_excl_o and rsp_err_o are 0.
- All registered AXI payloads are 0.
REQ-018 Reset mid-transaction abandons the AXI transaction with no completion. After release, the block accepts a new request in the first cycle.

Structure
REQ-019 Package axi_lrsc_init_pkg holds:
- Enum lrsc_op_e.
- Enum state_e.
- Constants RESP_OKAY = 2'b00, RESP_EXOKAY = 2'b01, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11.
REQ-020 The block is a single module with no sub-modules.

Verification
REQ-021 LR to 0x1000, size 3, slave returns r_resp = EXOKAY and data 0xDEAD -> one AR with lock = 1 and len = 0; rsp_rdata_o = 0xDEAD, rsp_excl_o = 1, rsp_err_o = 0.
REQ-022 SC to 0x1000, data 0x5, b_resp = EXOKAY -> AW with lock = 1 and W with last = 1 and data 0x5; rsp_rdata_o = 0, rsp_excl_o = 1. Repeat with b_resp = OKAY -> rsp_rdata_o = 1, rsp_excl_o = 0.
REQ-023 SC with w_ready held 0 for 5 cycles after the AW handshake -> aw_valid drops after its handshake while w_valid stays high; B is accepted only after the W handshake; one response is produced.
REQ-024 LR to 0x1004, size 3 -> no AR is issued; rsp_err_o = 1 within 2 cycles of acceptance.
REQ-025 STORE with b_resp = DECERR and rsp_ready_i held 0 for 4 cycles -> rsp_valid_o and the payload stay stable; req_ready_o = 0 until the response handshake.
REQ-026 rst_ni asserted while in R -> all valid outputs are 0 and req_ready_o = 1 immediately; a new LR completes normally after release.
